// File: rtl/sid_audio_pkg.sv
// Shared audio-path constants, FSM state type and saturation helper for the SID output chain.
// Combinational definitions only; no latency or backpressure of its own.
package sid_audio_pkg;
  localparam int SAMPLE_W   = 16;
  localparam int SID_DIV    = 12;
  localparam int DEF_SHIFT  = 3;
  localparam int DEF_STAGES = 3;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    LPF_IDLE,
    LPF_CALC,
    LPF_EMIT
  } lpf_state_t;

  // Clamp a signed value into the two's complement range of a w-bit word (w <= 31).
  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

// File: rtl/lpf_pole_step.sv
// One multiply-free one-pole update: y_next = y + ((x - y) >>> SHIFT).
// Purely combinational, zero latency, no flow control.
module lpf_pole_step
  import sid_audio_pkg::*;
#(
  parameter int A     = 20,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic signed [A-1:0] x,
  input  logic signed [A-1:0] y,
  output logic signed [A-1:0] y_next
);
  // One guard bit so the difference of two full-range values cannot wrap.
  logic signed [A:0] diff;

  assign diff   = $signed({x[A-1], x}) - $signed({y[A-1], y});
  assign y_next = A'($signed({y[A-1], y}) + (diff >>> SHIFT));
endmodule

// File: rtl/sid_lpf_decim.sv
// Time-multiplexed cascade of one-pole low-pass sections, one section per clock.
// VALID follows an accepted IN_EN by STAGES+1 edges; IN_EN outside IDLE is dropped and sets sticky OVR.
module sid_lpf_decim
  import sid_audio_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int SHIFT  = DEF_SHIFT,
  parameter int W      = SAMPLE_W
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                IN_EN,
  input  logic signed [W-1:0] IN,
  output logic signed [W-1:0] OUT,
  output logic                VALID,
  output logic                BUSY,
  output logic                OVR
);
  localparam int F    = SHIFT + 1;
  localparam int A    = W + F;
  localparam int IW   = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int HALF = 1 << (F - 1);

  lpf_state_t          state;
  lpf_state_t          state_nx;
  logic [IW-1:0]       idx;
  logic                last_stage;
  logic signed [A-1:0] x0;
  logic signed [A-1:0] acc [STAGES];
  logic signed [A-1:0] xs;
  logic signed [A-1:0] step;
  logic signed [W:0]   rounded;

  assign last_stage = (idx == IW'(STAGES - 1));
  assign BUSY       = (state != LPF_IDLE);

  // Stage s reads the value stage s-1 wrote on the previous clock.
  always_comb begin
    xs = x0;
    if (idx != '0) xs = acc[idx - IW'(1)];
  end

  lpf_pole_step #(
    .A     (A),
    .SHIFT (SHIFT)
  ) u_step (
    .x      (xs),
    .y      (acc[idx]),
    .y_next (step)
  );

  assign rounded = (W+1)'(($signed({acc[STAGES-1][A-1], acc[STAGES-1]}) + (A+1)'(HALF)) >>> F);

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= LPF_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LPF_IDLE: if (IN_EN) state_nx = LPF_CALC;
      LPF_CALC: if (last_stage) state_nx = LPF_EMIT;
      LPF_EMIT: state_nx = LPF_IDLE;
      default:  state_nx = LPF_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      idx   <= '0;
      x0    <= '0;
      OUT   <= '0;
      VALID <= 1'b0;
      OVR   <= 1'b0;
      for (int s = 0; s < STAGES; s++) acc[s] <= '0;
    end else begin
      VALID <= 1'b0;
      if (IN_EN && state != LPF_IDLE) OVR <= 1'b1;
      case (state)
        LPF_IDLE: begin
          if (IN_EN) begin
            x0  <= {IN, {F{1'b0}}};
            idx <= '0;
          end
        end
        LPF_CALC: begin
          acc[idx] <= step;
          idx      <= last_stage ? '0 : idx + IW'(1);
        end
        LPF_EMIT: begin
          OUT   <= W'(sat(32'(rounded), W));
          VALID <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sid_lpf_decim.sv
// Randomised and directed bench for sid_lpf_decim against a behavioural model.
module tb_sid_lpf_decim;
  import sid_audio_pkg::*;

  localparam int STAGES = DEF_STAGES;
  localparam int SHIFT  = DEF_SHIFT;
  localparam int F      = SHIFT + 1;

  logic    clk = 1'b0;
  logic    rst_n;
  logic    in_en;
  sample_t in_s;
  sample_t out_s;
  logic    valid;
  logic    busy;
  logic    ovr;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int vcount   = 0;

  sid_lpf_decim #(.STAGES(STAGES), .SHIFT(SHIFT), .W(SAMPLE_W)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .IN_EN (in_en),
    .IN    (in_s),
    .OUT   (out_s),
    .VALID (valid),
    .BUSY  (busy),
    .OVR   (ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input longint act, input longint req);
    tot_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
  endtask

  function automatic longint fdiv(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Behavioural model: filters each accepted sample at once, releases it STAGES+1 edges later.
  longint macc [STAGES];
  longint edge_k = 0;
  longint acc_edge = 0;
  bit     started = 0;
  bit     pending = 0;
  bit     m_valid = 0;
  bit     m_busy = 0;
  bit     m_ovr = 0;
  longint m_out = 0;
  longint m_res = 0;

  always @(posedge clk) begin
    longint xs;
    longint r;
    bit     emit_now;
    edge_k++;
    started = 1;
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) macc[s] = 0;
      m_out = 0; m_valid = 0; m_ovr = 0; pending = 0; m_busy = 0;
    end else begin
      m_valid  = 0;
      emit_now = pending && (edge_k == acc_edge + STAGES + 1);
      if (in_en) begin
        if (pending) m_ovr = 1;
        else begin
          pending  = 1;
          acc_edge = edge_k;
          for (int s = 0; s < STAGES; s++) begin
            xs = (s == 0) ? longint'(in_s) * (64'sd1 <<< F) : macc[s-1];
            macc[s] = macc[s] + fdiv(xs - macc[s], 64'sd1 <<< SHIFT);
          end
          r = fdiv(macc[STAGES-1] + (64'sd1 <<< (F - 1)), 64'sd1 <<< F);
          if (r > 32767) r = 32767;
          if (r < -32768) r = -32768;
          m_res = r;
        end
      end
      if (emit_now) begin
        m_out = m_res; m_valid = 1; pending = 0;
      end
      m_busy = pending;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      if (valid) vcount++;
      chk(valid == m_valid, "valid", longint'(valid), longint'(m_valid));
      chk(out_s == sample_t'(m_out), "out", longint'(out_s), m_out);
      chk(busy == m_busy, "busy", longint'(busy), longint'(m_busy));
      chk(ovr == m_ovr, "ovr", longint'(ovr), longint'(m_ovr));
    end
  end

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    in_en = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input sample_t v);
    in_s  = v;
    in_en = 1'b1;
    @(negedge clk);
    in_en = 1'b0;
    repeat (SID_DIV - 1) @(negedge clk);
  endtask

  task automatic run_dc(input sample_t v, input int n, input string nm);
    int  v0;
    int  prev;
    int  minv;
    bit  mono;
    do_reset(2);
    v0   = vcount;
    prev = 0;
    minv = 0;
    mono = 1;
    for (int i = 0; i < n; i++) begin
      send(v);
      if (v >= 0 && int'(out_s) < prev) mono = 0;
      if (v < 0 && int'(out_s) > prev) mono = 0;
      prev = int'(out_s);
      if (i == 0 || prev < minv) minv = prev;
    end
    chk(vcount - v0 == n, {nm, "_valid_count"}, vcount - v0, n);
    chk(mono, {nm, "_monotonic"}, mono, 1);
    if (v >= 0) begin
      // Floor truncation can leave the positive approach up to one LSB short.
      chk(int'(out_s) <= int'(v) && int'(out_s) >= int'(v) - 1, {nm, "_final"}, out_s, v);
      chk(minv >= 0, {nm, "_no_wrap"}, minv, 0);
    end else begin
      chk(out_s == v, {nm, "_final"}, out_s, v);
    end
  endtask

  initial begin
    int     v0;
    int     maxabs;
    int     g;
    rst_n = 1'b0;
    in_en = 1'b0;
    in_s  = '0;

    for (int i = 0; i < 3; i++) begin
      in_s  = 16'sd1234;
      in_en = (i % 2 == 0);
      @(negedge clk);
      chk(out_s == 0 && valid == 0 && busy == 0 && ovr == 0, "reset_hold",
          {out_s, 1'b0, valid, busy, ovr}, 0);
    end
    rst_n = 1'b1;
    in_en = 1'b0;

    run_dc(16'sd1000, 400, "dc_pos");
    run_dc(-16'sd1000, 400, "dc_neg");
    run_dc(16'sd32767, 400, "fs_pos");
    run_dc(-16'sd32768, 400, "fs_neg");

    do_reset(2);
    maxabs = 0;
    for (int i = 0; i < 400; i++) begin
      send((i % 2 == 0) ? 16'sd8000 : -16'sd8000);
      if (i >= 100) begin
        if (int'(out_s) > maxabs) maxabs = int'(out_s);
        if (-int'(out_s) > maxabs) maxabs = -int'(out_s);
      end
    end
    chk(maxabs <= 4, "nyquist_abs", maxabs, 4);

    do_reset(2);
    v0 = vcount;
    in_s = 16'sd800; in_en = 1'b1;
    @(negedge clk);
    in_en = 1'b0;
    @(negedge clk);
    in_s = 16'sd5000; in_en = 1'b1;
    @(negedge clk);
    in_en = 1'b0;
    repeat (15) @(negedge clk);
    chk(vcount - v0 == 1, "ovr_one_valid", vcount - v0, 1);
    chk(out_s == 16'sd2, "ovr_single_result", out_s, 2);
    chk(ovr == 1'b1, "ovr_set", ovr, 1);
    for (int i = 0; i < 5; i++) send(16'sd100);
    chk(ovr == 1'b1, "ovr_sticky", ovr, 1);
    do_reset(1);
    @(negedge clk);
    chk(ovr == 1'b0, "ovr_cleared", ovr, 0);

    do_reset(2);
    in_s = 16'sd800; in_en = 1'b1;
    @(negedge clk);
    in_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    v0 = vcount;
    repeat (10) @(negedge clk);
    chk(vcount == v0, "midreset_no_valid", vcount - v0, 0);
    chk(out_s == 0, "midreset_out", out_s, 0);
    chk(busy == 1'b0, "midreset_busy", busy, 0);
    send(16'sd800);
    chk(out_s == 16'sd2, "midreset_first_out", out_s, 2);

    do_reset(2);
    for (int i = 0; i < 300; i++) begin
      in_s  = sample_t'($urandom);
      in_en = 1'b1;
      @(negedge clk);
      in_en = 1'b0;
      g = $urandom_range(1, 14);
      repeat (g - 1) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    do_reset(1);
    @(negedge clk);
    chk(ovr == 1'b0 && out_s == 0, "final_reset", {out_s, ovr}, 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
